regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-read-port register file, successor to the single-write, two-read register memory in the decode stage. Adds:
- configurable width, depth and read-port count
- hardwired zero register
- write-to-read bypass
- sequential bulk-clear engine
- registered debug read port for the debug/UART unit

Sits in ID; the write port is driven from WB.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
N_RD, 2, number of combinational read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
rd_addr  in  N_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  N_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
wr_en  in  1  write enable
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
clr_req  in  1  start bulk clear (sampled in IDLE only)
clr_busy  out  1  high while clear engine runs
dbg_req  in  1  debug read request, single-cycle pulse
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  registered debug read data
dbg_valid  out  1  one-cycle pulse, dbg_data valid

Behaviour:
- Reset (reset=0, asynchronous): all registers 0, FSM=IDLE, clr_busy=0, dbg_valid=0, dbg_data=0. Reset mid-clear aborts immediately; all registers are 0 anyway.
- Write, IDLE only: at rising edge, if wr_en=1, reg[wr_addr] <= wr_data. Dropped if ZERO_REG=1 and wr_addr=0. Dropped silently in CLEAR.
- Read, combinational:
  - ZERO_REG=1 and rd_addr=0 -> 0.
  - Else if BYPASS=1, FSM=IDLE, wr_en=1, wr_addr==rd_addr -> wr_data.
  - Else reg[rd_addr].
  - All ports are independent; identical addresses are legal.
- Clear FSM, states IDLE and CLEAR:
  - IDLE->CLEAR on an edge with clr_req=1. A write in that same cycle is still performed.
  - In CLEAR: idx starts at 0; each cycle reg[idx] <= 0, idx++. After idx=DEPTH-1 is cleared, go to IDLE. This takes exactly DEPTH cycles.
  - clr_busy = (FSM==CLEAR), registered. It rises the cycle after the clr_req edge and falls after the last clear.
  - clr_req in CLEAR is ignored (no restart).
  - Reads in CLEAR return storage contents, bypass off; partially cleared contents are visible.
- Debug port:
  - dbg_req=1 at an edge captures the read of dbg_addr with the same rules as a read port, including bypass and zero. Result goes to dbg_data; dbg_valid=1 for the next cycle.
  - Latency 1. Back-to-back requests give back-to-back valids.
  - Served in both FSM states.
  - dbg_data holds its value when dbg_valid=0.
- Widths: no arithmetic other than idx (ADDR_W bits, wraps to 0 on exit). Out-of-range cannot occur since DEPTH=2**ADDR_W.

Decomposition:
- Shared package regfile_pkg:
  - state enum {IDLE, CLEAR}
  - default DATA_W/ADDR_W constants
  - function for the read-mux rule (zero, bypass, storage), reused by read ports and the debug port
- One sub-module, regfile_clr_fsm: state register, idx counter, clr_busy and write-inhibit outputs.
- Storage and read muxes stay in the top.

Test Plan:
1. Write 0xAAAABBBB to r1, 0x12345678 to r2; read rd_addr={r2,r1} -> rd_data port0=0xAAAABBBB, port1=0x12345678.
2. Zero register: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF; read r0 on all ports -> 0. Repeat with ZERO_REG=0 -> 0xFFFFFFFF after the edge.
3. Bypass: wr_en=1 to r10 with 0xDEADBEEF, rd_addr port0=r10 in the same cycle -> port0=0xDEADBEEF before the edge. With BYPASS=0 -> old value 0 before the edge.
4. Clear: fill r1..r31 with nonzero values, pulse clr_req -> clr_busy high exactly 32 cycles. wr_en to r5 with 0x55 during CLEAR is dropped. Afterwards all reads give 0.
5. Debug: r7=0xCAFEF00D; dbg_req with dbg_addr=7 -> next cycle dbg_valid=1, dbg_data=0xCAFEF00D. Then dbg_valid returns to 0 and dbg_data holds.
6. Reset mid-clear: drop reset at idx=10 -> immediately clr_busy=0, dbg_valid=0, all registers 0. After release, writes work from the first edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and the read-source selection rule for the multi-port register file.
// The rule is used by every combinational read port and by the debug port.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_e;

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_BYPASS,
        SEL_STORE
    } rd_sel_e;

    // The hardwired zero register takes priority over bypass.
    // Bypass is suppressed while the clear engine owns the storage.
    function automatic rd_sel_e read_sel(
        input logic zero_en,
        input logic bypass_en,
        input logic idle,
        input logic wr_en,
        input logic addr_zero,
        input logic addr_hit
    );
        if (zero_en && addr_zero) begin
            return SEL_ZERO;
        end
        if (bypass_en && idle && wr_en && addr_hit) begin
            return SEL_BYPASS;
        end
        return SEL_STORE;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, the WB write port, the clear control and the debug port.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_RD   = 2
);
    logic [N_RD*ADDR_W-1:0] rd_addr;
    logic [N_RD*DATA_W-1:0] rd_data;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   clr_req;
    logic                   clr_busy;
    logic                   dbg_req;
    logic [ADDR_W-1:0]      dbg_addr;
    logic [DATA_W-1:0]      dbg_data;
    logic                   dbg_valid;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, clr_req, dbg_req, dbg_addr,
        input  rd_data, clr_busy, dbg_data, dbg_valid
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, clr_req, dbg_req, dbg_addr,
        output rd_data, clr_busy, dbg_data, dbg_valid
    );
endinterface

// File: rtl/regfile_clr_fsm.sv
// Sequential bulk-clear engine: walks idx over every register, one per cycle,
// and blocks normal writes while it runs.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              wr_inhibit,
    output logic [ADDR_W-1:0] clr_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // idx wraps back to 0 on the final increment, so it is ready for the next run.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        clr_busy   = (state_q == CLEAR);
        wr_inhibit = (state_q == CLEAR);
        clr_idx    = idx_q;
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with N_RD combinational read ports, a zero register,
// write-to-read bypass, a bulk-clear engine and a registered debug read port.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic          clk,
    input logic          reset,
    regfile_mp_if.slave  bus
);

    localparam int   DEPTH     = 2 ** ADDR_W;
    localparam logic ZERO_EN   = (ZERO_REG != 0);
    localparam logic BYPASS_EN = (BYPASS != 0);

    logic [DATA_W-1:0]      mem_q [DEPTH];
    logic [DATA_W-1:0]      mem_d [DEPTH];
    logic [N_RD*DATA_W-1:0] rd_data_c;
    rd_sel_e                port_sel [N_RD];
    rd_sel_e                dbg_sel;
    logic                   dbg_valid_q, dbg_valid_d;
    logic [DATA_W-1:0]      dbg_data_q, dbg_data_d;
    logic                   clr_busy;
    logic                   wr_inhibit;
    logic [ADDR_W-1:0]      clr_idx;

    function automatic logic [DATA_W-1:0] pick(
        input rd_sel_e           sel,
        input logic [DATA_W-1:0] stored,
        input logic [DATA_W-1:0] fwd
    );
        case (sel)
            SEL_ZERO:   return '0;
            SEL_BYPASS: return fwd;
            default:    return stored;
        endcase
    endfunction

    regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_clr_fsm (
        .clk        (clk),
        .reset      (reset),
        .clr_req    (bus.clr_req),
        .clr_busy   (clr_busy),
        .wr_inhibit (wr_inhibit),
        .clr_idx    (clr_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dbg_valid_q <= 1'b0;
            dbg_data_q  <= '0;
        end else begin
            mem_q       <= mem_d;
            dbg_valid_q <= dbg_valid_d;
            dbg_data_q  <= dbg_data_d;
        end
    end

    // While clearing, the engine owns the single storage write path.
    always_comb begin
        mem_d = mem_q;
        if (wr_inhibit) begin
            mem_d[clr_idx] = '0;
        end else if (bus.wr_en && !(ZERO_EN && bus.wr_addr == '0)) begin
            mem_d[bus.wr_addr] = bus.wr_data;
        end
    end

    always_comb begin
        rd_data_c = '0;
        port_sel  = '{default: SEL_STORE};
        for (int k = 0; k < N_RD; k++) begin
            port_sel[k] = read_sel(ZERO_EN, BYPASS_EN, !wr_inhibit, bus.wr_en,
                                   bus.rd_addr[k*ADDR_W +: ADDR_W] == '0,
                                   bus.rd_addr[k*ADDR_W +: ADDR_W] == bus.wr_addr);
            rd_data_c[k*DATA_W +: DATA_W] = pick(port_sel[k],
                                                 mem_q[bus.rd_addr[k*ADDR_W +: ADDR_W]],
                                                 bus.wr_data);
        end
    end

    always_comb begin
        dbg_sel     = read_sel(ZERO_EN, BYPASS_EN, !wr_inhibit, bus.wr_en,
                               bus.dbg_addr == '0, bus.dbg_addr == bus.wr_addr);
        dbg_valid_d = bus.dbg_req;
        dbg_data_d  = dbg_data_q;
        if (bus.dbg_req) begin
            dbg_data_d = pick(dbg_sel, mem_q[bus.dbg_addr], bus.wr_data);
        end
    end

    assign bus.rd_data   = rd_data_c;
    assign bus.clr_busy  = clr_busy;
    assign bus.dbg_valid = dbg_valid_q;
    assign bus.dbg_data  = dbg_data_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: three instances (default, no zero register, no bypass)
// share one stimulus stream and are compared against a behavioural model through queues.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  rdAddr = '0;
    logic        wrEn = 1'b0;
    logic [4:0]  wrAddr = '0;
    logic [31:0] wrData = '0;
    logic        clrReq = 1'b0;
    logic        dbgReq = 1'b0;
    logic [4:0]  dbgAddr = '0;

    int checkCount = 0;
    int passCount = 0;

    typedef struct {
        int          dut;
        int          port;
        logic [31:0] value;
    } readExpT;

    readExpT     readQ[$];
    logic [31:0] dbgQ[3][$];
    logic [31:0] modelMem[3][32];
    logic [31:0] lastDbg[3];
    logic        modelBusy;
    logic [4:0]  modelIdx;
    bit          cfgZero[3]   = '{1'b1, 1'b0, 1'b1};
    bit          cfgBypass[3] = '{1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .N_RD(2)) bus0 ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .N_RD(2)) bus1 ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .N_RD(2)) bus2 ();

    assign bus0.rd_addr = rdAddr;  assign bus1.rd_addr = rdAddr;  assign bus2.rd_addr = rdAddr;
    assign bus0.wr_en = wrEn;      assign bus1.wr_en = wrEn;      assign bus2.wr_en = wrEn;
    assign bus0.wr_addr = wrAddr;  assign bus1.wr_addr = wrAddr;  assign bus2.wr_addr = wrAddr;
    assign bus0.wr_data = wrData;  assign bus1.wr_data = wrData;  assign bus2.wr_data = wrData;
    assign bus0.clr_req = clrReq;  assign bus1.clr_req = clrReq;  assign bus2.clr_req = clrReq;
    assign bus0.dbg_req = dbgReq;  assign bus1.dbg_req = dbgReq;  assign bus2.dbg_req = dbgReq;
    assign bus0.dbg_addr = dbgAddr; assign bus1.dbg_addr = dbgAddr; assign bus2.dbg_addr = dbgAddr;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk(clk), .reset(reset), .bus(bus0.slave));
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(0), .BYPASS(1)) u_dut_nz (
        .clk(clk), .reset(reset), .bus(bus1.slave));
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
        .clk(clk), .reset(reset), .bus(bus2.slave));

    function automatic logic [31:0] getRd(int c, int k);
        logic [63:0] v;
        case (c)
            0:       v = bus0.rd_data;
            1:       v = bus1.rd_data;
            default: v = bus2.rd_data;
        endcase
        return v[k*32 +: 32];
    endfunction

    function automatic logic [31:0] getDbgData(int c);
        case (c)
            0:       return bus0.dbg_data;
            1:       return bus1.dbg_data;
            default: return bus2.dbg_data;
        endcase
    endfunction

    function automatic logic getDbgValid(int c);
        case (c)
            0:       return bus0.dbg_valid;
            1:       return bus1.dbg_valid;
            default: return bus2.dbg_valid;
        endcase
    endfunction

    function automatic logic getBusy(int c);
        case (c)
            0:       return bus0.clr_busy;
            1:       return bus1.clr_busy;
            default: return bus2.clr_busy;
        endcase
    endfunction

    // Expected read result given the inputs currently driven and the pre-edge model state.
    function automatic logic [31:0] modelRead(int c, logic [4:0] a);
        if (cfgZero[c] && a == 5'd0) return 32'h0;
        if (cfgBypass[c] && !modelBusy && wrEn && wrAddr == a) return wrData;
        return modelMem[c][a];
    endfunction

    function automatic void resetModel();
        for (int c = 0; c < 3; c++) begin
            for (int a = 0; a < 32; a++) modelMem[c][a] = 32'h0;
            lastDbg[c] = 32'h0;
            dbgQ[c].delete();
        end
        readQ.delete();
        modelBusy = 1'b0;
        modelIdx  = 5'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    // Called just after a rising edge; drives one cycle, checks reads before the next edge
    // and the debug port / busy flag just after it.
    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [4:0] ra0, input logic [4:0] ra1,
                                 input logic cr, input logic dr, input logic [4:0] da);
        readExpT e;
        wrEn = we; wrAddr = wa; wrData = wd;
        rdAddr = {ra1, ra0};
        clrReq = cr; dbgReq = dr; dbgAddr = da;
        for (int c = 0; c < 3; c++) begin
            e.dut = c; e.port = 0; e.value = modelRead(c, ra0); readQ.push_back(e);
            e.dut = c; e.port = 1; e.value = modelRead(c, ra1); readQ.push_back(e);
            if (dr) dbgQ[c].push_back(modelRead(c, da));
        end
        @(negedge clk);
        while (readQ.size() > 0) begin
            e = readQ.pop_front();
            checkOutput($sformatf("rd dut%0d port%0d", e.dut, e.port), getRd(e.dut, e.port), e.value);
        end
        @(posedge clk);
        if (!modelBusy) begin
            for (int c = 0; c < 3; c++) begin
                if (we && !(cfgZero[c] && wa == 5'd0)) modelMem[c][wa] = wd;
            end
            if (cr) begin
                modelBusy = 1'b1;
                modelIdx  = 5'd0;
            end
        end else begin
            for (int c = 0; c < 3; c++) modelMem[c][modelIdx] = 32'h0;
            if (modelIdx == 5'd31) modelBusy = 1'b0;
            modelIdx = modelIdx + 5'd1;
        end
        #1;
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("busy dut%0d", c), {31'b0, getBusy(c)}, {31'b0, modelBusy});
            checkOutput($sformatf("dbg_valid dut%0d", c), {31'b0, getDbgValid(c)}, {31'b0, dr});
            if (dr && dbgQ[c].size() > 0) lastDbg[c] = dbgQ[c].pop_front();
            checkOutput($sformatf("dbg_data dut%0d", c), getDbgData(c), lastDbg[c]);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("reset busy dut%0d", c), {31'b0, getBusy(c)}, 32'h0);
            checkOutput($sformatf("reset dbg_valid dut%0d", c), {31'b0, getDbgValid(c)}, 32'h0);
            checkOutput($sformatf("reset dbg_data dut%0d", c), getDbgData(c), 32'h0);
        end
        reset = 1'b1;

        $display("[TB] basic write/read");
        applyStimulus(1'b1, 5'd1, 32'hAAAABBBB, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        applyStimulus(1'b1, 5'd2, 32'h12345678, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0);
        checkOutput("t1 port0", getRd(0, 0), 32'hAAAABBBB);
        checkOutput("t1 port1", getRd(0, 1), 32'h12345678);

        $display("[TB] zero register");
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        checkOutput("t2 zero r0", getRd(0, 1), 32'h0);
        checkOutput("t2 nozero r0", getRd(1, 1), 32'hFFFFFFFF);

        $display("[TB] bypass");
        applyStimulus(1'b1, 5'd10, 32'hDEADBEEF, 5'd10, 5'd10, 1'b0, 1'b0, 5'd0);
        applyStimulus(1'b1, 5'd11, 32'h0BADF00D, 5'd11, 5'd10, 1'b0, 1'b1, 5'd11);

        $display("[TB] debug port");
        applyStimulus(1'b1, 5'd7, 32'hCAFEF00D, 5'd3, 5'd7, 1'b0, 1'b0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 1'b1, 5'd7);
        checkOutput("t5 dbg_data", getDbgData(0), 32'hCAFEF00D);
        idle();
        checkOutput("t5 dbg hold", getDbgData(0), 32'hCAFEF00D);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b0, 1'b1, 5'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b0, 1'b1, 5'd2);
        applyStimulus(1'b1, 5'd0, 32'h77777777, 5'd0, 5'd2, 1'b0, 1'b1, 5'd0);
        idle();

        $display("[TB] bulk clear");
        for (int a = 1; a < 32; a++) begin
            applyStimulus(1'b1, 5'(a), $urandom | 32'h1, 5'(a), 5'(a - 1), 1'b0, 1'b0, 5'd0);
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 1'b1, 1'b0, 5'd0);
        cnt = 0;
        while (bus0.clr_busy && cnt < 40) begin
            applyStimulus(cnt == 20, 5'd5, 32'h55, 5'($urandom_range(0, 31)), 5'd5,
                          1'b1, cnt == 3, 5'd31);
            cnt++;
        end
        checkOutput("t4 busy cycles", 32'(cnt), 32'd32);
        for (int a = 0; a < 32; a += 2) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 5'(a), 5'(a + 1), 1'b0, 1'b0, 5'd0);
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 1'b0, 1'b0, 5'd0);
        checkOutput("t4 r5 dropped", getRd(0, 0), 32'h0);

        $display("[TB] reset during clear");
        for (int a = 1; a < 16; a++) begin
            applyStimulus(1'b1, 5'(a), 32'h1000 + 32'(a), 5'(a), 5'd0, 1'b0, 1'b0, 5'd0);
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 5'd12, 5'd15, 1'b0, i == 9, 5'd14);
        end
        reset = 1'b0;
        dbgReq = 1'b0;
        #1;
        resetModel();
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("t6 busy dut%0d", c), {31'b0, getBusy(c)}, 32'h0);
            checkOutput($sformatf("t6 dbg_valid dut%0d", c), {31'b0, getDbgValid(c)}, 32'h0);
        end
        for (int a = 0; a < 32; a += 2) begin
            rdAddr = {5'(a + 1), 5'(a)};
            #1;
            for (int c = 0; c < 3; c++) begin
                checkOutput($sformatf("t6 r%0d dut%0d", a, c), getRd(c, 0), 32'h0);
                checkOutput($sformatf("t6 r%0d dut%0d", a + 1, c), getRd(c, 1), 32'h0);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, 5'd4, 32'h4444ABCD, 5'd4, 5'd12, 1'b0, 1'b0, 5'd0);
        idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd13, 1'b0, 1'b0, 5'd0);
        checkOutput("t6 write after reset", getRd(0, 0), 32'h4444ABCD);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
